alarm_status_bank: RTL and testbench



---
 rtl/alarm_status_bank.sv | 187 ++++++++++++++++++
 tb/tb_alarm_status_bank.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_status_bank.sv
// alarm_status_bank: per-channel sticky W1C alarm status with level/rising-edge
// capture, interrupt enable mask and saturating occurrence counters, read and
// written through a small register window. One registered interrupt output.
module alarm_status_bank #(
    parameter int                    P_CHANNELS    = 8,
    parameter int                    P_DATA_WIDTH  = 32,
    parameter int                    P_CNT_WIDTH   = 8,
    parameter logic [P_CHANNELS-1:0] P_STATUS_INIT = {P_CHANNELS{1'b0}}
) (
    input  logic                    CLOCK,
    input  logic                    RESET,
    input  logic                    REG_SELECT,
    input  logic                    REG_WRITE,
    input  logic [2:0]              REG_ADDR,
    input  logic [P_DATA_WIDTH-1:0] DATA_IN,
    input  logic [P_CHANNELS-1:0]   ALARM_IN,
    output logic [P_DATA_WIDTH-1:0] DATA_OUT_Q,
    output logic                    IRQ_Q
);

    // Counter-select width; a single channel still gets one select bit.
    localparam int LP_SEL_W = (P_CHANNELS > 1) ? $clog2(P_CHANNELS) : 1;
    localparam logic [LP_SEL_W:0] LP_CH_NUM = (LP_SEL_W + 1)'(P_CHANNELS);

    localparam logic [2:0] LP_ADDR_STATUS  = 3'd0;
    localparam logic [2:0] LP_ADDR_ENABLE  = 3'd1;
    localparam logic [2:0] LP_ADDR_MODE    = 3'd2;
    localparam logic [2:0] LP_ADDR_CNT_SEL = 3'd3;
    localparam logic [2:0] LP_ADDR_CNT     = 3'd4;

    // Saturating increment: holds at all-ones instead of wrapping to zero.
    function automatic logic [P_CNT_WIDTH-1:0] sat_inc(input logic [P_CNT_WIDTH-1:0] v);
        if (v == {P_CNT_WIDTH{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + P_CNT_WIDTH'(1);
        end
    endfunction

    logic [P_CHANNELS-1:0]   status_q,     status_d;
    logic [P_CHANNELS-1:0]   enable_q,     enable_d;
    logic [P_CHANNELS-1:0]   mode_q,       mode_d;
    logic [LP_SEL_W-1:0]     cnt_sel_q,    cnt_sel_d;
    logic [P_CHANNELS-1:0]   alarm_prev_q, alarm_prev_d;
    logic [P_CNT_WIDTH-1:0]  cnt_q [P_CHANNELS];
    logic [P_CNT_WIDTH-1:0]  cnt_d [P_CHANNELS];
    logic [P_DATA_WIDTH-1:0] data_out_d;
    logic                    irq_d;

    logic                    wr_s;
    logic                    rd_s;
    logic [P_CHANNELS-1:0]   rise_s;
    logic [P_CHANNELS-1:0]   set_s;
    logic                    cnt_sel_ok_s;
    logic [LP_SEL_W-1:0]     cnt_idx_s;
    logic [P_DATA_WIDTH-1:0] rdata_s;
    logic                    unused_data_s;

    // Write-data bits above the implemented register widths are don't-care.
    assign unused_data_s = ^DATA_IN;

    // Bus strobe decode and capture conditions for each alarm channel.
    always_comb begin
        wr_s   = REG_SELECT & REG_WRITE;
        rd_s   = REG_SELECT & ~REG_WRITE;
        rise_s = ALARM_IN & ~alarm_prev_q;
        set_s  = (ALARM_IN & ~mode_q) | (rise_s & mode_q);
    end

    // Out-of-range counter selects fall back to counter 0 for reads and
    // block counter-clear writes.
    always_comb begin
        if ({1'b0, cnt_sel_q} < LP_CH_NUM) begin
            cnt_sel_ok_s = 1'b1;
            cnt_idx_s    = cnt_sel_q;
        end else begin
            cnt_sel_ok_s = 1'b0;
            cnt_idx_s    = {LP_SEL_W{1'b0}};
        end
    end

    // Status: a capture event always wins over a simultaneous W1C clear.
    always_comb begin
        status_d = status_q;
        for (int i = 0; i < P_CHANNELS; i++) begin
            if (set_s[i]) begin
                status_d[i] = 1'b1;
            end else if (wr_s && (REG_ADDR == LP_ADDR_STATUS) && DATA_IN[i]) begin
                status_d[i] = 1'b0;
            end else begin
                status_d[i] = status_q[i];
            end
        end
    end

    // Plain read/write configuration registers and the alarm history.
    always_comb begin
        enable_d     = enable_q;
        mode_d       = mode_q;
        cnt_sel_d    = cnt_sel_q;
        alarm_prev_d = ALARM_IN;
        if (wr_s) begin
            case (REG_ADDR)
                LP_ADDR_ENABLE:  enable_d  = DATA_IN[P_CHANNELS-1:0];
                LP_ADDR_MODE:    mode_d    = DATA_IN[P_CHANNELS-1:0];
                LP_ADDR_CNT_SEL: cnt_sel_d = DATA_IN[LP_SEL_W-1:0];
                default: begin
                    enable_d  = enable_q;
                    mode_d    = mode_q;
                    cnt_sel_d = cnt_sel_q;
                end
            endcase
        end else begin
            enable_d  = enable_q;
            mode_d    = mode_q;
            cnt_sel_d = cnt_sel_q;
        end
    end

    // Occurrence counters: clear first, then count, so clear+rise gives 1.
    always_comb begin
        for (int i = 0; i < P_CHANNELS; i++) begin
            if (wr_s && (REG_ADDR == LP_ADDR_CNT) && cnt_sel_ok_s && (int'(cnt_sel_q) == i)) begin
                cnt_d[i] = {P_CNT_WIDTH{1'b0}};
            end else begin
                cnt_d[i] = cnt_q[i];
            end
            if (rise_s[i]) begin
                cnt_d[i] = sat_inc(cnt_d[i]);
            end else begin
                cnt_d[i] = cnt_d[i];
            end
        end
    end

    // Read mux over pre-edge register values; unused bits read as zero.
    always_comb begin
        rdata_s = {P_DATA_WIDTH{1'b0}};
        case (REG_ADDR)
            LP_ADDR_STATUS:  rdata_s[P_CHANNELS-1:0]  = status_q;
            LP_ADDR_ENABLE:  rdata_s[P_CHANNELS-1:0]  = enable_q;
            LP_ADDR_MODE:    rdata_s[P_CHANNELS-1:0]  = mode_q;
            LP_ADDR_CNT_SEL: rdata_s[LP_SEL_W-1:0]    = cnt_sel_q;
            LP_ADDR_CNT:     rdata_s[P_CNT_WIDTH-1:0] = cnt_q[cnt_idx_s];
            default:         rdata_s                  = {P_DATA_WIDTH{1'b0}};
        endcase
    end

    // Read data is captured only on a read strobe; interrupt looks at the
    // next-state status and enable so it rises on the same edge as the bit.
    always_comb begin
        if (rd_s) begin
            data_out_d = rdata_s;
        end else begin
            data_out_d = DATA_OUT_Q;
        end
        irq_d = |(status_d & enable_d);
    end

    // State registers with synchronous reset that overrides all other activity.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            status_q     <= P_STATUS_INIT;
            enable_q     <= {P_CHANNELS{1'b0}};
            mode_q       <= {P_CHANNELS{1'b0}};
            cnt_sel_q    <= {LP_SEL_W{1'b0}};
            alarm_prev_q <= {P_CHANNELS{1'b0}};
            for (int i = 0; i < P_CHANNELS; i++) begin
                cnt_q[i] <= {P_CNT_WIDTH{1'b0}};
            end
            DATA_OUT_Q   <= {P_DATA_WIDTH{1'b0}};
            IRQ_Q        <= 1'b0;
        end else begin
            status_q     <= status_d;
            enable_q     <= enable_d;
            mode_q       <= mode_d;
            cnt_sel_q    <= cnt_sel_d;
            alarm_prev_q <= alarm_prev_d;
            for (int i = 0; i < P_CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            DATA_OUT_Q   <= data_out_d;
            IRQ_Q        <= irq_d;
        end
    end

endmodule

// File: tb/tb_alarm_status_bank.sv
// Self-checking bench for alarm_status_bank: a reference model predicts IRQ
// and read data; read expectations go through a scoreboard queue.
module tb_alarm_status_bank;

    localparam int CH = 8;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam logic [CH-1:0] INIT = 8'h05;

    logic          clk;
    logic          rst;
    logic          sel;
    logic          wen;
    logic [2:0]    addr;
    logic [DW-1:0] din;
    logic [CH-1:0] alm;
    logic [DW-1:0] dout;
    logic          irq;

    alarm_status_bank #(
        .P_CHANNELS   (CH),
        .P_DATA_WIDTH (DW),
        .P_CNT_WIDTH  (CW),
        .P_STATUS_INIT(INIT)
    ) dut (
        .CLOCK     (clk),
        .RESET     (rst),
        .REG_SELECT(sel),
        .REG_WRITE (wen),
        .REG_ADDR  (addr),
        .DATA_IN   (din),
        .ALARM_IN  (alm),
        .DATA_OUT_Q(dout),
        .IRQ_Q     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    logic [7:0]  m_status, m_enable, m_mode, m_prev;
    logic [2:0]  m_sel;
    logic [3:0]  m_cnt [8];
    logic        m_irq;
    logic [31:0] m_dout;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [2:0] a);
        logic [31:0] v;
        v = 32'd0;
        case (a)
            3'd0: v[7:0] = m_status;
            3'd1: v[7:0] = m_enable;
            3'd2: v[7:0] = m_mode;
            3'd3: v[2:0] = m_sel;
            3'd4: v[3:0] = m_cnt[m_sel];
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    // One clock: predict, clock the DUT, commit model, compare outputs.
    task automatic step(input bit use_exp, input logic [31:0] exp_v, input string tag);
        logic       wr, rd, was_rst;
        logic [7:0] rise, setv, nst, nen, nmode;
        logic [2:0] nsel;
        logic [3:0] ncnt [8];
        logic       nirq;
        logic [31:0] ndout;
        exp_t       e;
        wr = sel && wen;
        rd = sel && !wen;
        was_rst = rst;
        ndout = m_dout;
        if (rst) begin
            nst = INIT; nen = 8'h00; nmode = 8'h00; nsel = 3'd0;
            for (int i = 0; i < 8; i++) ncnt[i] = 4'd0;
            ndout = 32'd0;
        end else begin
            rise = alm & ~m_prev;
            setv = (alm & ~m_mode) | (rise & m_mode);
            nst  = m_status;
            if (wr && addr == 3'd0) nst = nst & ~din[7:0];
            nst   = nst | setv;
            nen   = (wr && addr == 3'd1) ? din[7:0] : m_enable;
            nmode = (wr && addr == 3'd2) ? din[7:0] : m_mode;
            nsel  = (wr && addr == 3'd3) ? din[2:0] : m_sel;
            for (int i = 0; i < 8; i++) begin
                ncnt[i] = (wr && addr == 3'd4 && int'(m_sel) == i) ? 4'd0 : m_cnt[i];
                if (rise[i] && ncnt[i] != 4'hF) ncnt[i] = ncnt[i] + 4'd1;
            end
            if (rd) begin
                e.tag = tag;
                e.val = use_exp ? exp_v : m_read(addr);
                sb_q.push_back(e);
                ndout = e.val;
            end
        end
        nirq = |(nst & nen);
        @(posedge clk);
        #1;
        m_status = nst; m_enable = nen; m_mode = nmode; m_sel = nsel;
        for (int i = 0; i < 8; i++) m_cnt[i] = ncnt[i];
        m_prev = was_rst ? 8'h00 : alm;
        m_irq  = nirq;
        m_dout = ndout;
        check_val("irq", {31'd0, irq}, {31'd0, m_irq});
        if (rd && !was_rst) begin
            if (sb_q.size() == 0) begin
                check_val("sb_empty", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_val(e.tag, dout, e.val);
            end
        end else begin
            check_val("dout_hold", dout, m_dout);
        end
    endtask

    task automatic idle(input int n);
        sel = 1'b0; wen = 1'b0;
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, "idle");
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        sel = 1'b1; wen = 1'b1; addr = a; din = d;
        step(1'b0, 32'd0, "wr");
        sel = 1'b0; wen = 1'b0;
    endtask

    task automatic rd_reg(input string tag, input logic [2:0] a, input logic [31:0] e);
        sel = 1'b1; wen = 1'b0; addr = a;
        step(1'b1, e, tag);
        sel = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; sel = 1'b0; wen = 1'b0; addr = 3'd0; din = 32'd0; alm = 8'h00;
        m_status = INIT; m_enable = 8'h00; m_mode = 8'h00; m_prev = 8'h00;
        m_sel = 3'd0; m_irq = 1'b0; m_dout = 32'd0;
        for (int i = 0; i < 8; i++) m_cnt[i] = 4'd0;
        idle(2);
        rst = 1'b0;

        // Reset values
        rd_reg("rst_status", 3'd0, 32'h05);
        rd_reg("rst_enable", 3'd1, 32'h00);
        rd_reg("rst_mode",   3'd2, 32'h00);
        rd_reg("rst_cntsel", 3'd3, 32'h00);
        for (int c = 0; c < 8; c++) begin
            wr_reg(3'd3, c);
            rd_reg("rst_cnt", 3'd4, 32'h0);
        end
        for (int a = 5; a < 8; a++) rd_reg("unmapped", a[2:0], 32'h0);

        // Level mode capture and clear
        wr_reg(3'd0, 32'h05);
        wr_reg(3'd1, 32'h01);
        alm = 8'h01;
        idle(1);
        check_val("lvl_irq_set", {31'd0, irq}, 32'd1);
        idle(2);
        alm = 8'h00;
        idle(1);
        rd_reg("lvl_status", 3'd0, 32'h01);
        wr_reg(3'd3, 32'd0);
        rd_reg("lvl_cnt0", 3'd4, 32'd1);
        wr_reg(3'd0, 32'h01);
        check_val("lvl_irq_clr", {31'd0, irq}, 32'd0);
        rd_reg("lvl_cleared", 3'd0, 32'h00);

        // Level clear blocked while alarm held
        alm = 8'h04;
        idle(1);
        wr_reg(3'd0, 32'h04);
        rd_reg("lvl_held", 3'd0, 32'h04);
        alm = 8'h00;
        wr_reg(3'd0, 32'h04);
        rd_reg("lvl_released", 3'd0, 32'h00);

        // Edge mode on channel 1
        wr_reg(3'd2, 32'h02);
        alm = 8'h02;
        idle(1);
        rd_reg("edge_set", 3'd0, 32'h02);
        wr_reg(3'd0, 32'h02);
        rd_reg("edge_clr_held", 3'd0, 32'h00);
        idle(2);
        rd_reg("edge_no_reset", 3'd0, 32'h00);
        alm = 8'h00;
        idle(1);
        alm = 8'h02;
        idle(1);
        rd_reg("edge_reset", 3'd0, 32'h02);
        wr_reg(3'd3, 32'd1);
        rd_reg("edge_cnt1", 3'd4, 32'd2);

        // Simultaneous clear and rise on channel 3, then clear+rise counter
        wr_reg(3'd2, 32'h0A);
        wr_reg(3'd3, 32'd3);
        wr_reg(3'd0, 32'hFF);
        alm = 8'h0A;
        wr_reg(3'd0, 32'h08);
        rd_reg("sim_clr_rise", 3'd0, 32'h08);
        alm = 8'h02;
        idle(1);
        alm = 8'h0A;
        wr_reg(3'd4, 32'd0);
        rd_reg("sim_cnt3", 3'd4, 32'd1);

        // Saturation on channel 5
        alm = 8'h00;
        wr_reg(3'd0, 32'hFF);
        wr_reg(3'd3, 32'd5);
        for (int k = 0; k < 20; k++) begin
            alm = 8'h20; idle(1);
            alm = 8'h00; idle(1);
        end
        rd_reg("sat_cnt5", 3'd4, 32'd15);
        wr_reg(3'd4, 32'd0);
        rd_reg("sat_clr", 3'd4, 32'd0);
        for (int k = 0; k < 3; k++) begin
            alm = 8'h20; idle(1);
            alm = 8'h00; idle(1);
        end
        rd_reg("burst_cnt5", 3'd4, 32'd3);

        // Reset mid-burst with alarm high across the release
        alm = 8'h20;
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check_val("mid_rst_irq", {31'd0, irq}, 32'd0);
        rd_reg("mid_rst_status", 3'd0, 32'h05);
        rd_reg("rise_after_rst", 3'd0, 32'h25);
        rd_reg("mid_rst_mode",   3'd2, 32'h00);
        rd_reg("mid_rst_cntsel", 3'd3, 32'h00);
        wr_reg(3'd3, 32'd5);
        rd_reg("mid_rst_cnt5", 3'd4, 32'd1);

        // Randomised traffic against the model
        for (int k = 0; k < 300; k++) begin
            alm  = $urandom;
            sel  = ($urandom_range(0, 3) != 0);
            wen  = $urandom_range(0, 1);
            addr = $urandom_range(0, 7);
            din  = $urandom;
            rst  = ($urandom_range(0, 63) == 0);
            step(1'b0, 32'd0, "rnd_rd");
        end
        rst = 1'b0;
        idle(1);
        check_val("sb_drained", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
